// File: rtl/sort_uniq_pkg.sv
// rtl/sort_uniq_pkg.sv - shared state encoding, default sizes and index-width helper for sort_uniq_ctrl
package sort_uniq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SORT,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam int DEF_N         = 8;
    localparam int DEF_WORD_SIZE = 4;
    localparam int DEF_TIMEOUT   = 256;

    // Sorter slots are numbered 1..n, so the index must be able to hold n itself.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sort_uniq_scan.sv
// rtl/sort_uniq_scan.sv - candidate register, duplicate compare, output stream and unique counter
module sort_uniq_scan
    import sort_uniq_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int IDX_W     = idx_width(DEF_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 active,
    input  logic                 first,
    input  logic                 tail,
    input  logic [WORD_SIZE-1:0] rd_data,
    input  logic                 out_ready,
    output logic                 step,
    output logic                 fin,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic [IDX_W-1:0]     uniq_count
);

    logic [WORD_SIZE-1:0] cand;
    logic                 differ;
    logic                 hs;

    // Everything below depends only on registered index/candidate and the sorter's
    // static contents, so the presented beat holds steady while stalled.
    always_comb begin
        differ    = (rd_data != cand);
        out_valid = active & (tail | (~first & differ));
        out_last  = active & tail;
        hs        = out_valid & out_ready;
        step      = active & ~tail & (first | ~differ | hs);
        fin       = active & tail & hs;
    end

    assign out_data = cand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand       <= '0;
            uniq_count <= '0;
        end else begin
            if (clr) begin
                uniq_count <= '0;
            end else if (hs) begin
                uniq_count <= uniq_count + IDX_W'(1);
            end
            if (active & ~tail & (first | hs)) begin
                cand <= rd_data;
            end
        end
    end

endmodule

// File: rtl/sort_uniq_ctrl.sv
// rtl/sort_uniq_ctrl.sv - job sequencer (fill, sort, unique scan); SORT_UNIQ_TIMEOUT_EN adds a sort watchdog
module sort_uniq_ctrl
    import sort_uniq_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int IDX_W     = idx_width(N),
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 srt_wr_en,
    output logic [IDX_W-1:0]     srt_wr_idx,
    output logic [WORD_SIZE-1:0] srt_wr_data,
    output logic                 srt_en,
    input  logic                 srt_done,
    output logic [IDX_W-1:0]     srt_rd_idx,
    input  logic [WORD_SIZE-1:0] srt_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic [IDX_W-1:0]     uniq_count,
    output logic                 err
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             tail;
    logic             sort_first;
    logic             start_job;
    logic             fill_hs;
    logic             scan_step;
    logic             scan_fin;
    logic             tmo_hit;

    assign start_job   = (state == ST_IDLE) & start;
    assign in_ready    = (state == ST_FILL);
    assign fill_hs     = in_ready & in_valid;
    assign srt_wr_en   = fill_hs;
    assign srt_wr_idx  = fill_idx;
    assign srt_wr_data = fill_hs ? in_data : '0;
    assign srt_en      = (state == ST_SORT) & sort_first;
    assign srt_rd_idx  = rd_idx;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_FILL;
            ST_FILL: if (fill_hs && fill_idx == LAST_IDX) state_nx = ST_SORT;
            ST_SORT: begin
                // srt_done is ignored in the srt_en cycle: a level left over from a
                // previous job must not be mistaken for completion.
                if (!sort_first && srt_done) state_nx = ST_SCAN;
                else if (tmo_hit) state_nx = ST_IDLE;
            end
            ST_SCAN: if (scan_fin) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fill_idx   <= FIRST_IDX;
            rd_idx     <= FIRST_IDX;
            tail       <= 1'b0;
            sort_first <= 1'b0;
        end else begin
            state      <= state_nx;
            sort_first <= (state == ST_FILL) && (state_nx == ST_SORT);
            if (start_job) begin
                fill_idx <= FIRST_IDX;
            end else if (fill_hs && fill_idx != LAST_IDX) begin
                fill_idx <= fill_idx + IDX_W'(1);
            end
            // Once slot N is consumed the index parks on N and tail marks the final beat.
            if (state == ST_SORT && state_nx == ST_SCAN) begin
                rd_idx <= FIRST_IDX;
                tail   <= 1'b0;
            end else if (scan_step) begin
                if (rd_idx == LAST_IDX) tail <= 1'b1;
                else rd_idx <= rd_idx + IDX_W'(1);
            end else if (state == ST_DONE) begin
                rd_idx <= FIRST_IDX;
                tail   <= 1'b0;
            end
        end
    end

`ifdef SORT_UNIQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // tmo_cnt counts completed post-pulse cycles; the hit fires on cycle TIMEOUT.
    assign tmo_hit = (state == ST_SORT) && !sort_first && !srt_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != ST_SORT || sort_first) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (start_job) err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    sort_uniq_scan #(
        .WORD_SIZE(WORD_SIZE),
        .IDX_W    (IDX_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_job),
        .active    (state == ST_SCAN),
        .first     ((rd_idx == FIRST_IDX) && !tail),
        .tail      (tail),
        .rd_data   (srt_rd_data),
        .out_ready (out_ready),
        .step      (scan_step),
        .fin       (scan_fin),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .uniq_count(uniq_count)
    );

endmodule

// File: tb/tb_sort_uniq_ctrl.sv
// tb/tb_sort_uniq_ctrl.sv - randomized self-checking bench for sort_uniq_ctrl with behavioural sorter and set model
`timescale 1ns/1ps
module tb_sort_uniq_ctrl;

    localparam int N       = 8;
    localparam int W       = 4;
    localparam int IDX_W   = $clog2(N + 1);
    localparam int TIMEOUT = 256;

    typedef logic [N-1:0][W-1:0] job_t;
    typedef logic [N:1][W-1:0]   mem_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             srt_wr_en;
    logic [IDX_W-1:0] srt_wr_idx;
    logic [W-1:0]     srt_wr_data;
    logic             srt_en;
    logic             srt_done;
    logic [IDX_W-1:0] srt_rd_idx;
    logic [W-1:0]     srt_rd_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic             busy;
    logic [IDX_W-1:0] uniq_count;
    logic             err;

    always #5 clk = ~clk;

    sort_uniq_ctrl #(.N(N), .WORD_SIZE(W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .srt_wr_en(srt_wr_en), .srt_wr_idx(srt_wr_idx),
        .srt_wr_data(srt_wr_data), .srt_en(srt_en), .srt_done(srt_done),
        .srt_rd_idx(srt_rd_idx), .srt_rd_data(srt_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .uniq_count(uniq_count), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Behavioural sorter: array of N slots, sorts after a random latency.
    mem_t mem;
    logic pending = 1'b0;
    bit   level_mode = 0;
    bit   hold_done = 0;
    int   lat = 0;

    function automatic mem_t sort_mem(input mem_t a);
        mem_t r = a;
        for (int i = 2; i <= N; i++)
            for (int j = i; j > 1 && r[j] < r[j-1]; j--) begin
                logic [W-1:0] t = r[j];
                r[j] = r[j-1];
                r[j-1] = t;
            end
        return r;
    endfunction

    assign srt_rd_data = mem[srt_rd_idx];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= 1'b0;
            srt_done <= 1'b0;
        end else if (srt_wr_en) begin
            mem[srt_wr_idx] <= srt_wr_data;
            pending  <= 1'b0;
            srt_done <= 1'b0;
        end else if (srt_en) begin
            pending  <= 1'b1;
            lat      <= $urandom_range(0, 4);
            srt_done <= 1'b0;
        end else if (pending) begin
            if (lat > 0) lat <= lat - 1;
            else if (!hold_done) begin
                mem      <= sort_mem(mem);
                pending  <= 1'b0;
                srt_done <= 1'b1;
            end
        end else if (!level_mode) begin
            srt_done <= 1'b0;
        end
    end

    // Output monitor: decides out_ready, scores handshakes, checks stall stability.
    logic [W-1:0] exp_q[$];
    int           got_cnt = 0;
    int           en_cnt = 0;
    int           rdy_mode = 0;
    bit           any_valid = 0;
    bit           stalled = 0;
    logic [W-1:0] st_data;
    logic         st_last;

    always @(negedge clk) begin
        bit r;
        logic [W-1:0] e;
        if (!rst) begin
            stalled   = 0;
            out_ready = 1'b0;
        end else begin
            if (srt_en) en_cnt++;
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, st_data);
                check("hold_last", out_last, st_last);
            end
            case (rdy_mode)
                0:       r = 1;
                1:       r = ~out_ready;
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                any_valid = 1;
                if (r) begin
                    got_cnt++;
                    if (exp_q.size() == 0) begin
                        check("extra_out", got_cnt, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e);
                        check("out_last", out_last, exp_q.size() == 0);
                    end
                end
            end
            stalled   = out_valid && !r;
            st_data   = out_data;
            st_last   = out_last;
            out_ready = r;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, srt_wr_en, 0);
        check({tag, "_wr_idx"}, srt_wr_idx, 1);
        check({tag, "_wr_data"}, srt_wr_data, 0);
        check({tag, "_srt_en"}, srt_en, 0);
        check({tag, "_rd_idx"}, srt_rd_idx, 1);
        check({tag, "_out"}, {out_valid, out_last, out_data}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_uniq"}, uniq_count, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Starts a job and streams its words; returns at the negedge where SORT begins.
    task automatic start_fill(input job_t w, input int mode, input bit lvl, input string name);
        bit seen [16];
        bit acc;
        int i, cyc;
        foreach (seen[v]) seen[v] = 0;
        for (int k = 0; k < N; k++) seen[w[k]] = 1;
        exp_q.delete();
        for (int v = 0; v < 16; v++) if (seen[v]) exp_q.push_back(W'(v));
        got_cnt = 0; en_cnt = 0; any_valid = 0;
        rdy_mode = mode; level_mode = lvl;
        in_valid = 1'b1; in_data = W'($urandom);
        @(negedge clk);
        check({name, "_idle_wr"}, srt_wr_en, 0);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({name, "_err_clr"}, err, 0);
        check({name, "_busy"}, busy, 1);
        i = N - 1; cyc = 0;
        while (i >= 0 && cyc < 200) begin
            acc = in_ready && ($urandom_range(0, 3) != 0);
            in_valid = acc;
            in_data = acc ? w[i] : W'($urandom);
            @(negedge clk);
            if (acc) i--;
            cyc++;
        end
        in_valid = 1'b0;
        check({name, "_filled"}, i < 0, 1);
        check({name, "_en_pulse"}, srt_en, 1);
    endtask

    task automatic finish_job(input int n_uniq, input string name);
        int cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_idle"}, busy, 0);
        check({name, "_outs"}, got_cnt, n_uniq);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_uniq"}, uniq_count, n_uniq);
        check({name, "_en_cnt"}, en_cnt, 1);
        check({name, "_err"}, err, 0);
    endtask

    task automatic run_job(input job_t w, input int mode, input bit lvl, input string name);
        int n;
        start_fill(w, mode, lvl, name);
        n = exp_q.size();
        finish_job(n, name);
    endtask

    initial begin
        job_t w;
        int   cnt, n;
        #2 rst = 1'b0;
        in_data = 4'hA;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b1;

        run_job({4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1}, 0, 0, "alt");
        run_job({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 0, 1, "desc");
        run_job({N{4'd5}}, 2, 0, "same");
        run_job({4'd3, 4'd3, 4'd9, 4'd1, 4'd9, 4'd1, 4'd0, 4'd0}, 1, 1, "toggle");

        hold_done = 1;
        start_fill({4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2}, 0, 0, "abort");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset("mid");
        @(negedge clk);
        check_reset("mid2");
        rst = 1'b1;
        hold_done = 0;
        run_job({4'd2, 4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4}, 0, 0, "post_rst");

        hold_done = 1;
`ifdef SORT_UNIQ_TIMEOUT_EN
        start_fill({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0}, 0, 0, "tmo");
        cnt = 0;
        while (!err && cnt < TIMEOUT + 20) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_err", err, 1);
        check("tmo_cycles", cnt, TIMEOUT + 1);
        check("tmo_idle", busy, 0);
        check("tmo_no_out", any_valid, 0);
        check("tmo_uniq", uniq_count, 0);
        hold_done = 0;
`else
        start_fill({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0}, 2, 0, "wait");
        n = exp_q.size();
        repeat (300) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_err", err, 0);
        check("wait_no_out", any_valid, 0);
        hold_done = 0;
        finish_job(n, "wait");
`endif
        run_job({4'd6, 4'd0, 4'd6, 4'd15, 4'd0, 4'd15, 4'd6, 4'd0}, 2, 0, "after");

        for (int t = 0; t < 10; t++) begin
            int hi = ($urandom_range(0, 1) != 0) ? 15 : 3;
            for (int k = 0; k < N; k++) w[k] = W'($urandom_range(0, hi));
            run_job(w, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sort_uniq_ctrl.md
# sort_uniq_ctrl

Controller that sequences the shared bubble-sort engine to produce the set of unique elements of an N-word job. It streams N words in, writes them into the sorter's array, starts the sort, waits for completion, then scans the sorted array and emits each distinct value once, in ascending order, on a valid/ready output stream. It sits between the job source and the sort datapath. It is the only master of the sorter's load, enable and read-index inputs.

## Interface
- N, 8, words per job (≥2)
- WORD_SIZE, 4, bits per word
- IDX_W, $clog2(N+1), sorter index width (slots 1..N)
- TIMEOUT, 256, max SORT-state cycles (used only with the watchdog)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin job; sampled in IDLE only
- in_valid  in  1  input word valid
- in_ready  out  1  high only in FILL
- in_data  in  WORD_SIZE  input word
- srt_wr_en  out  1  write in_data to sorter slot srt_wr_idx
- srt_wr_idx  out  IDX_W  sorter write slot, 1..N
- srt_wr_data  out  WORD_SIZE  sorter write data
- srt_en  out  1  one-cycle sort start pulse
- srt_done  in  1  sorter finished (level or pulse)
- srt_rd_idx  out  IDX_W  sorter read slot
- srt_rd_data  in  WORD_SIZE  combinational read of slot srt_rd_idx
- out_valid, out_ready  out/in  1  result handshake
- out_data  out  WORD_SIZE  unique value
- out_last  out  1  marks final unique value
- busy  out  1  high in all states except IDLE
- uniq_count  out  IDX_W  number of uniques of last job, held until next start
- err  out  1  sort timeout; sticky until next start

## Operation
- States: IDLE → FILL → SORT → SCAN → DONE → IDLE.
- IDLE: start=1 → FILL. Action on entry: clear the fill index to 1, uniq_count to 0 and err to 0.
- FILL: each in_valid&in_ready beat drives srt_wr_en=1, srt_wr_idx=fill index, srt_wr_data=in_data, then increments the index. After the beat that writes slot N → SORT.
- SORT: srt_en=1 on the first SORT cycle only. Wait for srt_done=1 on any later cycle → SCAN, with rd index=1.
- SCAN: srt_rd_idx = rd index.
  - At idx 1: load the candidate with srt_rd_data and advance the index.
  - At idx k>1, if srt_rd_data equals the candidate: advance the index, emit nothing.
  - At idx k>1, if srt_rd_data differs: present the candidate on out_data with out_valid=1 and out_last=0. On the handshake, load the candidate with srt_rd_data, increment uniq_count and advance the index. Without the handshake, stall with idx and out_data held.
  - After idx N is consumed: present the candidate with out_last=1. On the handshake, increment uniq_count → DONE.
- DONE: one cycle, then → IDLE.
- start outside IDLE is ignored. in_valid outside FILL is ignored.
- Equality compare is full WORD_SIZE, unsigned.

## Timing
- Reset: state IDLE; every output 0, except srt_rd_idx=1 and srt_wr_idx=1.
- Reset asserted mid-job aborts the job immediately. No partial output completes. The sorter contents are don't-care.
- FILL accepts one word per cycle; minimum N cycles.
- srt_en is high exactly one cycle per job.
- SCAN fetches one slot per cycle when not stalled. With out_ready tied high, SCAN takes N+1 cycles.
- out_data, out_valid and out_last must not change while out_valid=1 and out_ready=0.
- uniq_count is final from the DONE cycle onward.

## Configuration
- SORT_UNIQ_TIMEOUT_EN defined:
  - A counter runs in SORT.
  - If srt_done has not arrived within TIMEOUT cycles after the srt_en pulse: set err=1, go to IDLE, emit no output, leave uniq_count=0.
- SORT_UNIQ_TIMEOUT_EN undefined: SORT waits indefinitely, and err is tied 0.

## Structure
- Shared package sort_uniq_pkg holds:
  - state enum (IDLE, FILL, SORT, SCAN, DONE)
  - default N, WORD_SIZE and TIMEOUT constants
  - index width function
- Sub-module sort_uniq_scan holds the candidate register, compare, output-stream holding logic and uniq_count. The top-level FSM drives it with scan start and index-advance controls.

## Test plan
- Job 8,1,8,1,8,1,8,1, out_ready=1 → outputs 1, then 8 with out_last; uniq_count=2; srt_en pulsed once.
- Job 7,6,5,4,3,2,1,0 → outputs 0..7 in order, out_last on 7, uniq_count=8.
- Job of all 5s → single output 5 with out_last, uniq_count=1.
- Job 3,3,9,1,9,1,0,0 with out_ready toggling 1/0 each cycle → outputs 0,1,3,9; values stable during stalls; uniq_count=4.
- rst pulled low during SORT of a job, then released and job 2,2,2,2,4,4,4,4 run → only 2, 4 emitted; all outputs 0 during reset.
- With SORT_UNIQ_TIMEOUT_EN, srt_done held 0 → err=1 after TIMEOUT cycles, return to IDLE, no out_valid; the next start clears err.
